uart_mmio_tx: RTL
=================

// Module: uart_mmio_tx
// PURPOSE
//  MMIO-driven UART transmitter: the outbound counterpart of the UART programmer's receive path.
//  - Accepts bytes from the Memory stage (mmio_wea/mmio_dat) into a small FIFO.
//  - Serializes them 8N1, LSB first, onto tx.
//  - Reports space/busy status back to the core through mmio_read.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
//  FIFO_DEPTH    16   byte FIFO entries; power of 2, 2..256
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  Rst         in   1   synchronous, active-high reset
//  mmio_wea    in   1   write strobe from Memory stage; one byte per asserted cycle
//  mmio_dat    in   32  write data; only [7:0] transmitted, [31:8] ignored
//  mmio_read   out  1   1 = FIFO not full (write will be accepted this cycle)
//  tx          out  1   serial line, idle high
//  tx_busy     out  1   1 = frame in progress or FIFO non-empty
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow    out  1   sticky: a write arrived while FIFO full; cleared only by Rst
// BEHAVIOUR
//  Reset values: tx=1, mmio_read=1, tx_busy=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO flushed.
//  Reset during a frame: tx=1 after the reset edge; any partial frame is abandoned.
//  Write acceptance:
//  - Decided on pre-edge occupancy: accepted iff mmio_wea && count<FIFO_DEPTH.
//  - A same-cycle pop never makes room for a same-cycle write.
//  - Write while full: byte dropped, overflow<=1, FIFO contents unchanged.
//  Counter arithmetic: fifo_count += push - pop; pointers wrap modulo FIFO_DEPTH.
//  FSM states IDLE, START, DATA, [PARITY], STOP; baud counter bcnt 0..CLKS_PER_BIT-1; bit index 0..7.
//  - IDLE:   tx=1; if FIFO non-empty, pop into shift register, bcnt=0, go to START.
//  - START:  tx=0 for CLKS_PER_BIT cycles, then DATA.
//  - DATA:   tx=shift[0] each bit period; shift right at period end; after bit 7 go to STOP
//            (PARITY when UART_TX_PARITY_EN is defined).
//  - STOP:   tx=1 for CLKS_PER_BIT cycles. On the last cycle, if FIFO non-empty, pop and go
//            straight to START (zero idle gap); otherwise go to IDLE.
//  Latency: write with FIFO empty and FSM IDLE at edge E0 -> pop at E1 -> tx=0 after E2.
//  Frame length: 10*CLKS_PER_BIT cycles (11* with parity). tx is registered, glitch-free.
//  tx_busy = (state!=IDLE) || (fifo_count!=0), registered alongside state.
// CONFIGURATION
//  Macro UART_TX_PARITY_EN:
//  - Defined: PARITY state after DATA drives tx = ^byte (even parity) for one bit period;
//    frame is 8E1.
//  - Undefined: no PARITY state and no parity logic; frame is 8N1.
//  - The UART programmer receive path must be built with the same setting.
// STRUCTURE
//  Package uart_pkg:
//  - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t
//  - localparam int UART_DATA_BITS = 8
//  - localparam logic UART_IDLE_LEVEL = 1'b1
//  Sub-module uart_tx_fifo: sync FIFO with params DEPTH/WIDTH.
//  - Ports: push, pop, din, dout, count, full, empty.
//  - dout valid from the head entry (first-word-fall-through).
//  Top level holds the FSM, baud counter, shift register and overflow flag.
// TESTING (simulate with CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Rst high 3 cycles, then low -> tx=1, mmio_read=1, tx_busy=0, fifo_count=0, overflow=0.
//  2. Write 0x000000A5 once while idle.
//     -> tx=0 two edges later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1;
//        tx_busy falls after 40 cycles.
//  3. Write 0x55, 0x0F, 0x3C on consecutive cycles.
//     -> three frames back-to-back with no idle cycle between stop and next start;
//        fifo_count peaks at 2.
//  4. Six consecutive writes while idle.
//     -> mmio_read=0 once full; the 6th write is dropped; overflow=1 and stays 1.
//     -> exactly 5 bytes sent in order (1 popped early + 4 in FIFO).
//  5. Rst asserted mid-DATA of a frame with 2 bytes queued.
//     -> tx=1 after next edge, fifo_count=0, no further frames.
//  6. UART_TX_PARITY_EN defined, write 0x07.
//     -> parity bit=1 sent after bit 7; frame 44 cycles.
//     -> with 0x03: parity bit=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmit path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head output.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  // Head is read combinationally so the consumer sees the byte before popping it.
  assign dout    = mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == AW'(gi)))
          mem[gi] <= din;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO-fed UART transmitter: byte FIFO in front of an 8N1 serializer.
// Define UART_TX_PARITY_EN for an 8E1 frame with an even-parity bit after the data.
module uart_mmio_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          mmio_wea,
  input  logic [31:0]                   mmio_dat,
  output logic                          mmio_read,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BCNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state_reg, state_next;
  logic [15:0]    bcnt_reg, bcnt_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tx_reg, tx_next;
  logic           busy_reg, busy_next;
  logic           overflow_reg;
`ifdef UART_TX_PARITY_EN
  logic           par_reg, par_next;
`endif

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  count_next;
  logic           period_end;
  logic           unused_dat;

  assign unused_dat = &{1'b0, mmio_dat[31:8]};
  assign fifo_push  = mmio_wea && !fifo_full;
  assign period_end = (bcnt_reg == BCNT_LAST);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mmio_dat[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg    <= IDLE;
      bcnt_reg     <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= UART_IDLE_LEVEL;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      bcnt_reg     <= bcnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      overflow_reg <= overflow_reg | (mmio_wea & fifo_full);
`ifdef UART_TX_PARITY_EN
      par_reg      <= par_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    bcnt_next    = bcnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    fifo_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next     = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          bcnt_next  = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          par_next   = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (period_end) begin
          bcnt_next    = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          bcnt_next = bcnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (period_end) begin
          bcnt_next    = '0;
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          bcnt_next = bcnt_reg + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (period_end) begin
          bcnt_next  = '0;
          state_next = STOP;
        end else begin
          bcnt_next = bcnt_reg + 16'd1;
        end
      end
`endif
      STOP: begin
        if (period_end) begin
          bcnt_next = '0;
          // Chain the next queued byte straight into a start bit: no idle gap.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_dout;
            state_next = START;
`ifdef UART_TX_PARITY_EN
            par_next   = ^fifo_dout;
`endif
          end else begin
            state_next = IDLE;
          end
        end else begin
          bcnt_next = bcnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next = UART_IDLE_LEVEL;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_reg;
`endif
      STOP:    tx_next = 1'b1;
      default: tx_next = UART_IDLE_LEVEL;
    endcase
    count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    busy_next  = (state_next != IDLE) || (count_next != '0);
  end

  assign mmio_read = !fifo_full;
  assign tx        = tx_reg;
  assign tx_busy   = busy_reg;
  assign overflow  = overflow_reg;
endmodule
